// File: rtl/sync_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_updown_counter
// Brief    : Presettable synchronous up/down modulo-N counter with P/T enables,
//            active-low ripple carry and registered terminal-count pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sync_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2**WIDTH,
  parameter int DFF_RISE = 5,
  parameter int DFF_FALL = 5
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             CLRn,
  input  logic             LOADn,
  input  logic             U_Dn,
  input  logic             ENABLE_Pn,
  input  logic             ENABLE_Tn,
  input  logic [WIDTH-1:0] DATA,
  output logic [WIDTH-1:0] Q,
  output logic             RCOn,
  output logic             TCR
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

  // Output delays are a simulation-model notion only; here they are merely range-checked.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("sync_updown_counter: WIDTH must be 1..16");
  end
  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS must be 2..2**WIDTH");
  end
  if (DFF_RISE < 0 || DFF_FALL < 0) begin : g_bad_delay
    $error("sync_updown_counter: DFF_RISE/DFF_FALL must be non-negative");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_tcr;
  logic             w_terminal;
  logic             w_count;
  logic [WIDTH-1:0] w_up_next;
  logic [WIDTH-1:0] w_dn_next;

  always_comb begin
    w_terminal = U_Dn ? (r_q == c_max) : (r_q == '0);
    w_count    = CLRn & LOADn & ~ENABLE_Pn & ~ENABLE_Tn;
    // Out-of-range values (>= MODULUS after a load) fold back to zero going up.
    w_up_next  = (r_q >= c_max) ? '0 : r_q + 1'b1;
    w_dn_next  = (r_q == '0) ? c_max : r_q - 1'b1;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_q   <= '0;
      r_tcr <= 1'b0;
    end else if (!CLRn) begin
      r_q   <= '0;
      r_tcr <= 1'b0;
    end else if (!LOADn) begin
      r_q   <= DATA;
      r_tcr <= 1'b0;
    end else if (w_count) begin
      r_q   <= U_Dn ? w_up_next : w_dn_next;
      // Only a count that leaves the exact terminal state is a wrap.
      r_tcr <= w_terminal;
    end else begin
      r_tcr <= 1'b0;
    end
  end

  assign Q    = r_q;
  assign RCOn = ~(~ENABLE_Tn & w_terminal);
  assign TCR  = r_tcr;

endmodule
`default_nettype wire

// File: doc/sync_updown_counter.md
SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter/data width in bits, legal range 1..16.
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH: count length, legal range 2..2**WIDTH; 10 with WIDTH=4 gives decade operation.
REQ-003 SHALL have parameter DFF_RISE, default 5, and DFF_FALL, default 5: simulation-only rise/fall delay in ns on Q; ignored by synthesis.
REQ-004 CLOCK  input  1  single clock; all state changes on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 CLRn  input  1  synchronous clear, active low.
REQ-007 LOADn  input  1  synchronous parallel load, active low.
REQ-008 U_Dn  input  1  direction: 1 = count up, 0 = count down.
REQ-009 ENABLE_Pn  input  1  count enable P, active low.
REQ-010 ENABLE_Tn  input  1  count enable T, active low; also gates RCOn.
REQ-011 DATA  input  WIDTH  parallel load value, bit 0 = LSB.
REQ-012 Q  output  WIDTH  counter state, bit 0 = LSB.
REQ-013 RCOn  output  1  combinational ripple carry/borrow, active low.
REQ-014 TCR  output  1  registered terminal-count pulse, active high.

Function
REQ-015 Priority per rising edge SHALL be: RESET > CLRn low > LOADn low > count > hold.
REQ-016 CLRn low SHALL set Q to 0 on the next edge, regardless of LOADn, enables or U_Dn.
REQ-017 LOADn low (CLRn high) SHALL set Q to DATA on the next edge, regardless of enables; latency 1 clock.
REQ-018 Count SHALL occur only when CLRn=1, LOADn=1, ENABLE_Pn=0 and ENABLE_Tn=0; otherwise Q holds.
REQ-019 Up count: Q >= MODULUS-1 -> 0; else Q+1.
REQ-020 Down count: Q == 0 -> MODULUS-1; Q > MODULUS-1 -> Q-1 (binary); else Q-1.
REQ-021 Loaded DATA >= MODULUS SHALL be stored unchanged; the next up-count SHALL go to 0.
REQ-022 Terminal state SHALL be Q == MODULUS-1 when U_Dn=1, and Q == 0 when U_Dn=0.
REQ-023 RCOn SHALL be 0 exactly when ENABLE_Tn=0 and Q is in the terminal state; it does not depend on ENABLE_Pn, LOADn, CLRn or CLOCK.
REQ-024 RCOn SHALL follow a U_Dn change combinationally, with no clock edge.
REQ-025 TCR SHALL be 1 for exactly the one cycle after an edge on which a count wrapped Q (terminal -> 0 up, 0 -> MODULUS-1 down); otherwise 0.
REQ-026 Load or clear into a terminal value SHALL NOT assert TCR.
REQ-027 Multiple instances SHALL cascade synchronously: RCOn of the lower stage drives ENABLE_Tn of the next, with a shared CLOCK.
REQ-028 When WIDTH=4 and MODULUS=16, Q and RCOn SHALL match a 4-bit synchronous up/down binary counter with P/T enables cycle for cycle.

Reset
REQ-029 RESET=1 SHALL immediately force Q=0 and TCR=0, without waiting for a clock edge.
REQ-030 While RESET=1, RCOn SHALL still evaluate combinationally: 0 if ENABLE_Tn=0 and U_Dn=0.
REQ-031 Release of RESET SHALL take effect asynchronously; the first edge after release SHALL behave per REQ-015.
REQ-032 RESET asserted mid-count or mid-load SHALL abandon the operation, with no partial update.

Verification
REQ-033 WIDTH=4, MODULUS=16, U_Dn=1, enables 0, 17 clocks from 0 -> Q 1..15,0,1; RCOn=0 only at Q=15; TCR=1 in the cycle Q=0.
REQ-034 WIDTH=4, MODULUS=10, U_Dn=0, load 3, then 5 counts -> Q 2,1,0,9,8; RCOn=0 at Q=0; TCR=1 in the cycle Q=9.
REQ-035 MODULUS=10, load DATA=13, count up -> Q=0 on the next edge with TCR=0; load 9 -> TCR stays 0.
REQ-036 CLRn=0 and LOADn=0 with DATA=5 on the same edge -> Q=0; ENABLE_Pn=1 with ENABLE_Tn=0 at Q=15 up -> Q holds 15, RCOn=0.
REQ-037 Two WIDTH=4 instances cascaded, up, 256 clocks from 0 -> 8-bit sequence 0..255,0; upper stage increments only when lower RCOn=0.
REQ-038 RESET pulse of 3 ns between edges at Q=7 -> Q=0 at once, no clock needed; counting resumes 1,2 on subsequent edges.
